// File: rtl/bcrypt_hash_decode.sv
//==============================================================================
// bcrypt_hash_decode: byte-serial parser for "$2v$cc$<22 salt><31 hash>" strings.
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module bcrypt_hash_decode #(
    parameter int MIN_COST = 4,
    parameter int MAX_COST = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [5:0]   cost,
    output logic [127:0] salt,
    output logic [183:0] hash,
    output logic         done,
    output logic         err,
    output logic         busy
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_V1   = 4'd1;
    localparam logic [3:0] S_V2   = 4'd2;
    localparam logic [3:0] S_S1   = 4'd3;
    localparam logic [3:0] S_C1   = 4'd4;
    localparam logic [3:0] S_C0   = 4'd5;
    localparam logic [3:0] S_S2   = 4'd6;
    localparam logic [3:0] S_SALT = 4'd7;
    localparam logic [3:0] S_HASH = 4'd8;
    localparam logic [3:0] S_DONE = 4'd9;
    localparam logic [3:0] S_ERR  = 4'd10;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [6:0] COST_LO   = 7'(MIN_COST);
    localparam logic [6:0] COST_HI   = 7'(MAX_COST);

    logic [3:0]   state_q, state_d;
    logic [4:0]   cnt_q;
    logic [3:0]   c1_q;
    logic [6:0]   cost_stg_q;
    logic [127:0] salt_stg_q;
    // Shift registers hold all characters but the last; the full 132/186-bit
    // words are formed combinationally when the final character arrives.
    logic [125:0] salt_sh_q;
    logic [179:0] hash_sh_q;
    logic [5:0]   cost_q;
    logic [127:0] salt_q;
    logic [183:0] hash_q;

    logic         w_accept;
    logic         w_is_digit;
    logic         w_cost_ok;
    logic [6:0]   w_cost_calc;
    logic         w_b64_ok;
    logic [5:0]   w_b64_val;
    logic [131:0] w_salt_shift;
    logic [185:0] w_hash_shift;

    assign w_accept     = in_valid && in_ready;
    assign w_is_digit   = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign w_cost_calc  = ({3'b000, c1_q} * 7'd10) + {3'b000, in_data[3:0]};
    assign w_cost_ok    = (cost_stg_q >= COST_LO) && (cost_stg_q <= COST_HI);
    assign w_salt_shift = {salt_sh_q, w_b64_val};
    assign w_hash_shift = {hash_sh_q, w_b64_val};

    // bcrypt base64 alphabet: "./A-Za-z0-9"
    always_comb begin
        w_b64_ok  = 1'b1;
        w_b64_val = 6'd0;
        if (in_data == 8'h2E) begin
            w_b64_val = 6'd0;
        end else if (in_data == 8'h2F) begin
            w_b64_val = 6'd1;
        end else if ((in_data >= 8'h41) && (in_data <= 8'h5A)) begin
            w_b64_val = 6'(in_data - 8'h3F);
        end else if ((in_data >= 8'h61) && (in_data <= 8'h7A)) begin
            w_b64_val = 6'(in_data - 8'h45);
        end else if (w_is_digit) begin
            w_b64_val = 6'(in_data + 8'd6);
        end else begin
            w_b64_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DONE, S_ERR: state_d = S_IDLE;
            default: begin
                if (w_accept) begin
                    case (state_q)
                        S_IDLE: if (in_data == CH_DOLLAR) state_d = S_V1;
                        S_V1:   state_d = (in_data == 8'h32) ? S_V2 : S_ERR;
                        S_V2:   state_d = ((in_data == 8'h61) || (in_data == 8'h62) ||
                                           (in_data == 8'h79)) ? S_S1 : S_ERR;
                        S_S1:   state_d = (in_data == CH_DOLLAR) ? S_C1 : S_ERR;
                        S_C1:   state_d = w_is_digit ? S_C0 : S_ERR;
                        S_C0:   state_d = w_is_digit ? S_S2 : S_ERR;
                        S_S2:   state_d = ((in_data == CH_DOLLAR) && w_cost_ok) ? S_SALT : S_ERR;
                        S_SALT: begin
                            if (!w_b64_ok)            state_d = S_ERR;
                            else if (cnt_q == 5'd21)  state_d = S_HASH;
                        end
                        S_HASH: begin
                            if (!w_b64_ok)            state_d = S_ERR;
                            else if (cnt_q == 5'd30)  state_d = S_DONE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q != S_DONE) && (state_q != S_ERR);
        done     = (state_q == S_DONE);
        err      = (state_q == S_ERR);
        busy     = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            c1_q       <= '0;
            cost_stg_q <= '0;
            salt_stg_q <= '0;
            salt_sh_q  <= '0;
            hash_sh_q  <= '0;
            cost_q     <= '0;
            salt_q     <= '0;
            hash_q     <= '0;
        end else if (state_q == S_ERR) begin
            cnt_q      <= '0;
            cost_stg_q <= '0;
            salt_stg_q <= '0;
            salt_sh_q  <= '0;
            hash_sh_q  <= '0;
        end else if (w_accept) begin
            case (state_q)
                S_C1: c1_q       <= in_data[3:0];
                S_C0: cost_stg_q <= w_cost_calc;
                S_S2: begin
                    cnt_q     <= '0;
                    salt_sh_q <= '0;
                end
                S_SALT: begin
                    if (w_b64_ok) begin
                        salt_sh_q <= w_salt_shift[125:0];
                        if (cnt_q == 5'd21) begin
                            salt_stg_q <= w_salt_shift[131:4];
                            hash_sh_q  <= '0;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                S_HASH: begin
                    if (w_b64_ok) begin
                        hash_sh_q <= w_hash_shift[179:0];
                        if (cnt_q == 5'd30) begin
                            cost_q <= cost_stg_q[5:0];
                            salt_q <= salt_stg_q;
                            hash_q <= w_hash_shift[185:2];
                            cnt_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cost = cost_q;
    assign salt = salt_q;
    assign hash = hash_q;

endmodule

`default_nettype wire

// File: tb/tb_bcrypt_hash_decode.sv
//==============================================================================
// tb_bcrypt_hash_decode: directed self-checking bench for bcrypt_hash_decode.
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bcrypt_hash_decode;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   cost;
    logic [127:0] salt;
    logic [183:0] hash;
    logic         done;
    logic         err;
    logic         busy;

    bcrypt_hash_decode #(.MIN_COST(4), .MAX_COST(31)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cost     (cost),
        .salt     (salt),
        .hash     (hash),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] SALT_A   = {{5{24'h041041 << 1}}, 8'h08};
    localparam logic [183:0] HASH_SL  = {{7{24'h041041}}, 16'h0410};
    localparam logic [127:0] SALT_SL  = {{5{24'h041041}}, 8'h04};
    localparam logic [183:0] HASH_A   = {{7{24'h082082}}, 16'h0820};
    localparam logic [183:0] ALL_ONES = {184{1'b1}};

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int nrdy_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (done === 1'b1)     done_cnt++;
            if (err === 1'b1)      err_cnt++;
            if (in_ready === 1'b0) nrdy_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [183:0] got, input logic [183:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("ready_timeout", 184'(in_ready), 184'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_text(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 0);
    endtask

    // Full 60-byte string; the final byte never gets a trailing gap
    task automatic send_str(input logic [7:0] ver, input logic [7:0] d1, input logic [7:0] d0,
                            input logic [7:0] sc, input logic [7:0] hc, input int gap);
        send_byte(8'h24, gap); send_byte(8'h32, gap); send_byte(ver, gap);
        send_byte(8'h24, gap); send_byte(d1, gap);    send_byte(d0, gap);
        send_byte(8'h24, gap);
        for (int i = 0; i < 22; i++) send_byte(sc, gap);
        for (int i = 0; i < 30; i++) send_byte(hc, gap);
        send_byte(hc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int r0;
        int d0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 184'(in_ready), 184'd1);
        chk("rst_busy",  184'(busy),     184'd0);
        chk("rst_done",  184'(done),     184'd0);
        chk("rst_err",   184'(err),      184'd0);
        chk("rst_cost",  184'(cost),     184'd0);
        chk("rst_salt",  184'(salt),     184'd0);
        chk("rst_hash",  hash,           184'd0);
        rst = 1'b0;

        // Back-to-back valid stream
        send_str("a", "1", "2", "A", "/", 0);
        chk("t1_done",  184'(done),     184'd1);
        chk("t1_ready", 184'(in_ready), 184'd0);
        chk("t1_cost",  184'(cost),     184'd12);
        chk("t1_salt",  184'(salt),     184'(SALT_A));
        chk("t1_hash",  hash,           HASH_SL);
        @(posedge clk); #1;
        chk("t1_done_off", 184'(done), 184'd0);
        chk("t1_idle",     184'(busy), 184'd0);

        // Valid low on every other cycle
        send_str("b", "1", "2", "A", "/", 1);
        chk("t2_done", 184'(done), 184'd1);
        chk("t2_cost", 184'(cost), 184'd12);
        chk("t2_salt", 184'(salt), 184'(SALT_A));
        chk("t2_hash", hash,       HASH_SL);
        @(posedge clk); #1;

        // Cost below minimum
        send_text("$2a$03$");
        chk("t3_err",   184'(err),      184'd1);
        chk("t3_ready", 184'(in_ready), 184'd0);
        chk("t3_cost",  184'(cost),     184'd12);
        chk("t3_salt",  184'(salt),     184'(SALT_A));
        chk("t3_hash",  hash,           HASH_SL);
        @(posedge clk); #1;
        chk("t3_err_off", 184'(err),  184'd0);
        chk("t3_idle",    184'(busy), 184'd0);
        send_str("y", "0", "4", ".", "9", 0);
        chk("t3b_done", 184'(done), 184'd1);
        chk("t3b_cost", 184'(cost), 184'd4);
        chk("t3b_salt", 184'(salt), 184'd0);
        chk("t3b_hash", hash,       ALL_ONES);
        @(posedge clk); #1;

        // Cost above maximum
        send_text("$2a$32$");
        chk("t3c_err", 184'(err), 184'd1);
        @(posedge clk); #1;

        // Bad version byte
        e0 = err_cnt;
        r0 = nrdy_cnt;
        send_text("$2x");
        chk("t4_err", 184'(err), 184'd1);
        @(posedge clk); #1;
        chk("t4_idle",     184'(busy),            184'd0);
        chk("t4_err_cnt",  184'(err_cnt - e0),    184'd1);
        chk("t4_nrdy_cnt", 184'(nrdy_cnt - r0),   184'd1);

        // Non-alphabet byte inside the salt
        e0 = err_cnt;
        send_text("$2b$10$AAAAA#");
        chk("t4b_err", 184'(err), 184'd1);
        @(posedge clk); #1;
        chk("t4b_idle",    184'(busy),         184'd0);
        chk("t4b_err_cnt", 184'(err_cnt - e0), 184'd1);

        // Garbage before a valid string, cost at maximum
        e0 = err_cnt;
        send_text("zz9");
        chk("t5_garbage_idle", 184'(busy), 184'd0);
        send_str("y", "3", "1", "A", "/", 0);
        chk("t5_done", 184'(done), 184'd1);
        chk("t5_cost", 184'(cost), 184'd31);
        chk("t5_salt", 184'(salt), 184'(SALT_A));
        chk("t5_hash", hash,       HASH_SL);
        @(posedge clk); #1;
        chk("t5_no_err", 184'(err_cnt - e0), 184'd0);

        // Reset after the 30th byte
        d0 = done_cnt;
        send_text("$2a$12$");
        for (int i = 0; i < 22; i++) send_byte("A", 0);
        send_byte("/", 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_busy", 184'(busy), 184'd0);
        chk("t6_cost", 184'(cost), 184'd0);
        chk("t6_salt", 184'(salt), 184'd0);
        chk("t6_hash", hash,       184'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("t6_no_done", 184'(done_cnt - d0), 184'd0);
        send_str("a", "1", "3", "/", "A", 0);
        chk("t6b_done", 184'(done), 184'd1);
        chk("t6b_cost", 184'(cost), 184'd13);
        chk("t6b_salt", 184'(salt), 184'(SALT_SL));
        chk("t6b_hash", hash,       HASH_A);
        @(posedge clk); #1;

        chk("total_done", 184'(done_cnt), 184'd5);
        chk("total_err",  184'(err_cnt),  184'd4);
        chk("total_nrdy", 184'(nrdy_cnt), 184'd9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
